// File: rtl/weight3_seq_ctrl.sv
// Layer-3 weight bank sequencer: forward row sweeps and backprop commit strobes,
// arbitrated so they never overlap, with a saturating count of committed updates.
module weight3_seq_ctrl #(
  parameter int N_ROWS  = 5,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fwd_start,
  input  logic               upd_start,
  output logic               delta_hold,
  input  logic               row_ready,
  output logic [3:0]         ctrl,
  output logic [3:0]         sel,
  output logic               row_valid,
  output logic [3:0]         row_idx,
  output logic               row_last,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] upd_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // 4'b1111 is the bank's commit code, which is why N_ROWS stops at 15
  localparam logic [3:0] COMMIT_CODE = 4'b1111;
  localparam logic [3:0] LAST_ROW    = 4'(N_ROWS - 1);

  state_t             state, state_nxt;
  logic [3:0]         row_q, row_nxt;
  logic               pend_fwd, pend_fwd_nxt;
  logic               pend_upd, pend_upd_nxt;
  logic [COUNT_W-1:0] count_q, count_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_q    <= '0;
      pend_fwd <= 1'b0;
      pend_upd <= 1'b0;
      count_q  <= '0;
    end else begin
      state    <= state_nxt;
      row_q    <= row_nxt;
      pend_fwd <= pend_fwd_nxt;
      pend_upd <= pend_upd_nxt;
      count_q  <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_nxt      = row_q;
    pend_fwd_nxt = pend_fwd;
    pend_upd_nxt = pend_upd;
    count_nxt    = count_q;

    // Requests arriving while busy are remembered one deep; repeats merge.
    if (state != IDLE) begin
      if (fwd_start) pend_fwd_nxt = 1'b1;
      if (upd_start) pend_upd_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (upd_start || pend_upd) begin
          state_nxt    = COMMIT;
          pend_upd_nxt = 1'b0;
          if (fwd_start) pend_fwd_nxt = 1'b1;
        end else if (fwd_start || pend_fwd) begin
          state_nxt    = SWEEP;
          row_nxt      = '0;
          pend_fwd_nxt = 1'b0;
        end
      end
      SWEEP: begin
        if (row_ready) begin
          if (row_q == LAST_ROW) state_nxt = DONE;
          else                   row_nxt   = row_q + 4'd1;
        end
      end
      COMMIT: begin
        state_nxt = DONE;
        if (count_q != {COUNT_W{1'b1}}) count_nxt = count_q + COUNT_W'(1);
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    ctrl      = '0;
    sel       = '0;
    row_valid = 1'b0;
    done      = 1'b0;

    case (state)
      SWEEP: begin
        ctrl      = row_q;
        row_valid = 1'b1;
      end
      COMMIT: begin
        ctrl = COMMIT_CODE;
        // Reset landing on the commit cycle must suppress the strobe immediately.
        sel  = rst ? 4'b0000 : COMMIT_CODE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase

    row_idx    = row_valid ? row_q : 4'd0;
    row_last   = row_valid && (row_q == LAST_ROW);
    busy       = (state != IDLE);
    delta_hold = pend_upd || (state == COMMIT);
    upd_count  = count_q;
  end

endmodule

// File: tb/tb_weight3_seq_ctrl.sv
// Self-checking bench for weight3_seq_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic compared against a behavioural model.
module tb_weight3_seq_ctrl;

  localparam int N_ROWS  = 5;
  localparam int COUNT_W = 2;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               fwd_start;
  logic               upd_start;
  logic               row_ready;
  logic               delta_hold;
  logic [3:0]         ctrl;
  logic [3:0]         sel;
  logic               row_valid;
  logic [3:0]         row_idx;
  logic               row_last;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] upd_count;

  weight3_seq_ctrl #(.N_ROWS(N_ROWS), .COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fwd_start  (fwd_start),
    .upd_start  (upd_start),
    .delta_hold (delta_hold),
    .row_ready  (row_ready),
    .ctrl       (ctrl),
    .sel        (sel),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .busy       (busy),
    .done       (done),
    .upd_count  (upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: row being presented (-1 when none), commit/done cycle flags,
  // one-deep pending requests and the saturating commit count.
  int m_row    = -1;
  bit m_commit = 1'b0;
  bit m_done   = 1'b0;
  bit m_pf     = 1'b0;
  bit m_pu     = 1'b0;
  int m_cnt    = 0;

  typedef struct {
    bit f, u, r, rs;
    int e_ctrl, e_sel, e_rv, e_last, e_done, e_busy, e_dh, e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic modelStep(input bit f, input bit u, input bit r, input bit rs);
    int n_row;
    bit n_commit, n_done, npf, npu, idle;
    if (rs) begin
      m_row = -1; m_commit = 0; m_done = 0; m_pf = 0; m_pu = 0; m_cnt = 0;
      return;
    end
    idle = (m_row < 0) && !m_commit && !m_done;
    n_row = -1; n_commit = 0; n_done = 0; npf = m_pf; npu = m_pu;
    if (idle) begin
      if (u || m_pu) begin
        n_commit = 1; npu = 0;
        if (f) npf = 1;
      end else if (f || m_pf) begin
        n_row = 0; npf = 0;
      end
    end else begin
      if (f) npf = 1;
      if (u) npu = 1;
      if (m_row >= 0) begin
        if (!r)                  n_row = m_row;
        else if (m_row == N_ROWS - 1) n_done = 1;
        else                     n_row = m_row + 1;
      end else if (m_commit) begin
        n_done = 1;
        m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
    end
    m_row = n_row; m_commit = n_commit; m_done = n_done; m_pf = npf; m_pu = npu;
  endtask

  task automatic applyStimulus(input bit f, input bit u, input bit r, input bit rs);
    fwd_start = f;
    upd_start = u;
    row_ready = r;
    rst       = rs;
    @(posedge clk);
    modelStep(f, u, r, rs);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    int e_ctrl;
    e_ctrl = (m_row >= 0) ? m_row : (m_commit ? 15 : 0);
    chk({tag, ".ctrl"},       int'(ctrl),       e_ctrl);
    chk({tag, ".sel"},        int'(sel),        (m_commit && !rst) ? 15 : 0);
    chk({tag, ".row_valid"},  int'(row_valid),  int'(m_row >= 0));
    chk({tag, ".row_idx"},    int'(row_idx),    (m_row >= 0) ? m_row : 0);
    chk({tag, ".row_last"},   int'(row_last),   int'(m_row == N_ROWS - 1));
    chk({tag, ".busy"},       int'(busy),       int'((m_row >= 0) || m_commit || m_done));
    chk({tag, ".done"},       int'(done),       int'(m_done));
    chk({tag, ".delta_hold"}, int'(delta_hold), int'(m_pu || m_commit));
    chk({tag, ".upd_count"},  int'(upd_count),  m_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int strobes;
    int cnt_before;
    int busy_seen;
    int sat_exp[5];

    fwd_start = 0; upd_start = 0; row_ready = 0; rst = 1;

    //                f  u  r  rs  ctrl sel rv last done busy dh cnt
    vecs.push_back('{0, 0, 0, 1,   0,   0, 0, 0,   0,   0,  0, 0});
    vecs.push_back('{1, 0, 1, 0,   0,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 1, 0,   1,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 1, 0,   2,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 0, 0,   2,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 0, 0,   2,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 0, 0,   2,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 1, 0,   3,   0, 1, 0,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 1, 0,   4,   0, 1, 1,   0,   1,  0, 0});
    vecs.push_back('{0, 0, 1, 0,   0,   0, 0, 0,   1,   1,  0, 0});
    vecs.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   0,   0,  0, 0});
    vecs.push_back('{1, 1, 0, 0,  15,  15, 0, 0,   0,   1,  1, 0});
    vecs.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   1,   1,  0, 1});
    vecs.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   0,   0,  0, 1});
    vecs.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   1,  0, 1});
    vecs.push_back('{0, 0, 1, 1,   0,   0, 0, 0,   0,   0,  0, 0});
    vecs.push_back('{0, 1, 0, 0,  15,  15, 0, 0,   0,   1,  1, 0});
    vecs.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   1,   1,  0, 1});
    vecs.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   0,   0,  0, 1});

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].f, vecs[i].u, vecs[i].r, vecs[i].rs);
      chk({tag, ".ctrl"},       int'(ctrl),       vecs[i].e_ctrl);
      chk({tag, ".sel"},        int'(sel),        vecs[i].e_sel);
      chk({tag, ".row_valid"},  int'(row_valid),  vecs[i].e_rv);
      chk({tag, ".row_idx"},    int'(row_idx),    vecs[i].e_rv ? vecs[i].e_ctrl : 0);
      chk({tag, ".row_last"},   int'(row_last),   vecs[i].e_last);
      chk({tag, ".done"},       int'(done),       vecs[i].e_done);
      chk({tag, ".busy"},       int'(busy),       vecs[i].e_busy);
      chk({tag, ".delta_hold"}, int'(delta_hold), vecs[i].e_dh);
      chk({tag, ".upd_count"},  int'(upd_count),  vecs[i].e_cnt);
    end

    // Three upd_start pulses during a stalled sweep merge into one commit.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("merge_start");
    cnt_before = int'(upd_count);
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, (k % 2) == 0, 0, 0);
      checkOutput($sformatf("merge_stall%0d", k));
      if (sel == 4'hF) strobes++;
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("merge_drain%0d", k));
      if (sel == 4'hF) strobes++;
    end
    chk("merge.commit_strobes", strobes, 1);
    chk("merge.count_delta", int'(upd_count) - cnt_before, 1);

    // Reset on row 3 discards the sweep and both pending requests.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    chk("rst_sweep.row3", int'(ctrl), 3);
    checkOutput("rst_sweep.pre");
    applyStimulus(0, 0, 1, 1);
    checkOutput("rst_sweep.post");
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("rst_sweep.idle%0d", k));
      if (busy || row_valid || sel != 4'h0) busy_seen++;
    end
    chk("rst_sweep.no_later_activity", busy_seen, 0);

    // Reset arriving in the commit cycle suppresses the strobe and the count.
    applyStimulus(0, 1, 0, 0);
    checkOutput("rst_commit.pre");
    rst = 1;
    #1;
    chk("rst_commit.sel_masked", int'(sel), 0);
    applyStimulus(0, 0, 0, 1);
    chk("rst_commit.upd_count", int'(upd_count), 0);
    checkOutput("rst_commit.post");

    // Counter saturates at all-ones with a 2-bit width.
    sat_exp = '{1, 2, 3, 3, 3};
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      chk($sformatf("sat.count%0d", k), int'(upd_count), sat_exp[k]);
      applyStimulus(0, 0, 0, 0);
    end

    // Randomized traffic against the model.
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom % 4) == 0, ($urandom % 8) == 0,
                    ($urandom % 3) != 0, ($urandom % 150) == 0);
      checkOutput($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
